// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the pipeline around it.
// Contents:
//   md_op_e     - operation encodings presented on md_op
//   md_state_e  - FSM state codes of the multiply/divide sequencer
//   cnt_width() - width needed for a busy counter covering both latencies
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2
  } md_state_e;

  // Bits needed to hold max(a, b) - 1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    if (m <= 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: HI/LO multiply/divide unit with a fixed-latency busy window.
// A mult/multu/div/divu accepted in IDLE latches its operands and keeps the
// unit busy for MULT_CYCLES / DIV_CYCLES cycles; the result is computed from
// the latched operands in the final busy cycle and written to HI/LO on the
// edge that returns the FSM to IDLE. mthi/mtlo write directly in IDLE.
// Ports:
//   clk       - clock, rising edge
//   reset_n   - synchronous active-low reset
//   start     - E-stage instruction valid for this unit
//   md_op     - operation (md_op_e encoding)
//   src_a     - rs operand
//   src_b     - rt operand
//   d_is_md   - D-stage instruction touches the HI/LO unit
//   busy      - multi-cycle operation in progress
//   md_stall  - stall request to the hazard logic
//   hi, lo    - architectural HI/LO registers
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic             sgn_q, sgn_d;   // latched op is the signed variant
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  // Multiply: sign- or zero-extend to 64 bits; low 64 bits of the product
  // are correct for both interpretations.
  logic [63:0] ext_a, ext_b, prod;
  assign ext_a = {{32{sgn_q & opa_q[31]}}, opa_q};
  assign ext_b = {{32{sgn_q & opb_q[31]}}, opb_q};
  assign prod  = ext_a * ext_b;

  // Divide on magnitudes, then restore signs: quotient negative when the
  // operand signs differ, remainder takes the dividend's sign. The
  // 0x80000000 / -1 case falls out naturally (magnitude 2^31 fits unsigned).
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, uquot, urem, quot, rem;
  assign neg_a = sgn_q & opa_q[31];
  assign neg_b = sgn_q & opb_q[31];
  assign mag_a = neg_a ? (32'd0 - opa_q) : opa_q;
  assign mag_b = neg_b ? (32'd0 - opb_q) : opb_q;
  assign uquot = (mag_b != 32'd0) ? (mag_a / mag_b) : 32'd0;
  assign urem  = (mag_b != 32'd0) ? (mag_a % mag_b) : 32'd0;
  assign quot  = (neg_a ^ neg_b) ? (32'd0 - uquot) : uquot;
  assign rem   = neg_a ? (32'd0 - urem) : urem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              state_d = ST_MUL_RUN;
              cnt_d   = MUL_LOAD;
              opa_d   = src_a;
              opb_d   = src_b;
              sgn_d   = (md_op == MD_MULT);
            end
            MD_DIV, MD_DIVU: begin
              state_d = ST_DIV_RUN;
              cnt_d   = DIV_LOAD;
              opa_d   = src_a;
              opb_d   = src_b;
              sgn_d   = (md_op == MD_DIV);
            end
            MD_MTHI: hi_d = src_a;
            MD_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      ST_MUL_RUN: begin
        if (cnt_q == '0) begin
          state_d      = ST_IDLE;
          {hi_d, lo_d} = prod;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DIV_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          // Divide by zero still burns the full latency but leaves HI/LO alone.
          if (opb_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // A D-stage HI/LO access must wait while the unit is busy or is about to
  // become busy this very cycle.
  assign md_stall = d_is_md & (busy | (start & ((md_op == MD_MULT) | (md_op == MD_MULTU) |
                                                (md_op == MD_DIV)  | (md_op == MD_DIVU))));

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, number of busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, number of busy cycles for div/divu.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-005 start  input  1  E-stage instruction valid for this unit this cycle.
REQ-006 md_op  input  3  operation: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 src_a  input  32  E-stage forwarded rs value.
REQ-008 src_b  input  32  E-stage forwarded rt value.
REQ-009 d_is_md  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 busy  output  1  multi-cycle operation in progress.
REQ-011 md_stall  output  1  stall request to hazard logic.
REQ-012 hi  output  32  HI register.
REQ-013 lo  output  32  LO register.

Function
REQ-014 FSM states IDLE, MUL_RUN, DIV_RUN; busy = (state != IDLE).
REQ-015 IDLE + start + MULT/MULTU -> MUL_RUN, counter loaded MULT_CYCLES-1; operands latched at that edge.
REQ-016 IDLE + start + DIV/DIVU -> DIV_RUN, counter loaded DIV_CYCLES-1; operands latched at that edge.
REQ-017 Start accepted at edge t: busy high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), starting after edge t.
REQ-018 Counter decrements each cycle in MUL_RUN/DIV_RUN; at count 0, next edge -> IDLE and hi/lo updated, so new hi/lo visible in the first cycle busy is low.
REQ-019 MULT: {hi,lo} = signed 32x32 -> 64-bit product; MULTU: unsigned product.
REQ-020 DIV: lo = quotient truncated toward zero, hi = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-021 DIV with src_a=0x80000000, src_b=0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
REQ-022 Divisor zero (DIV or DIVU): full DIV_CYCLES busy period runs; hi/lo unchanged at completion.
REQ-023 MTHI/MTLO with start in IDLE: hi (resp. lo) <= src_a at next edge; busy stays low; other register unchanged.
REQ-024 start while busy: ignored entirely (no operand latch, no hi/lo write, no counter reload).
REQ-025 start with md_op NONE or undefined encoding: no state change.
REQ-026 md_stall = d_is_md AND (busy OR (start AND md_op in {MULT,MULTU,DIV,DIVU})); purely combinational.
REQ-027 Back-to-back: operation may start in the first cycle busy is low; it reads hi/lo only via completed values.
REQ-028 hi/lo outputs driven directly from registers; never expose intermediate results.

Reset
REQ-029 reset_n low at rising edge: state=IDLE, counter=0, hi=0, lo=0, latched operands=0.
REQ-030 Reset mid-operation aborts the operation; no result is written; busy low in the cycle after the reset edge.
REQ-031 Reset has priority over start and completion in the same cycle.

Structure
REQ-032 md_op encodings (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6) and FSM state codes reside in the shared definitions header used by the pipeline.
REQ-033 Counter width sized to hold max(MULT_CYCLES, DIV_CYCLES)-1.
REQ-034 No sub-module; arithmetic computed from latched operands in the completion cycle.

Verification
REQ-035 start MULT, src_a=0xFFFFFFFE (-2), src_b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-036 start DIVU, src_a=17, src_b=5 -> busy high 10 cycles, then lo=3, hi=2; DIV src_a=-7, src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 hi=lo=0x1234 preloaded via MTHI/MTLO, then DIV by 0 -> busy 10 cycles, hi=lo=0x1234 afterwards.
REQ-038 start MULT then start DIV on cycle 2 of busy -> DIV ignored, MULT result only, busy falls after 5 cycles.
REQ-039 d_is_md=1 during busy -> md_stall=1; d_is_md=1 with start MULTU in IDLE -> md_stall=1 same cycle; d_is_md=0 -> md_stall=0.
REQ-040 reset_n low on busy cycle 3 of DIV -> next cycle busy=0, hi=lo=0, no later write.
